// File: rtl/cell_fetch_pkg.sv
// Shared definitions for the cell stream fetcher: FSM states, border flag
// bit positions and the layout of the per-read sideband tag.
// Tag layout (TAG_W bits): {flags[3:0], sof, eof}.
package cell_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // Bit positions inside the 4-bit border flag field
  localparam int FLG_T = 3;
  localparam int FLG_B = 2;
  localparam int FLG_L = 1;
  localparam int FLG_R = 0;

  localparam int TAG_W   = 6;
  localparam int TAG_SOF = 1;
  localparam int TAG_EOF = 0;

  function automatic logic [TAG_W-1:0] pack_tag(input logic top, input logic bottom,
                                                input logic left, input logic right,
                                                input logic sof, input logic eof);
    logic [3:0] flags;
    flags        = '0;
    flags[FLG_T] = top;
    flags[FLG_B] = bottom;
    flags[FLG_L] = left;
    flags[FLG_R] = right;
    return {flags, sof, eof};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with the head word visible combinationally on rd_data.
// Latency: a word written at edge N is readable from the cycle after edge N.
// Backpressure: full blocks writes unless a read happens the same cycle.
// Ports: clk/rst (sync, active-high), wr_en/wr_data/full, rd_en/rd_data/empty,
// count = current occupancy.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Depth need not be a power of two, so pointers wrap explicitly
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      if (do_wr && !do_rd)      count <= count + CNT_W'(1);
      else if (do_rd && !do_wr) count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cell_stream_fetch.sv
// Streams one frame of cells from the cell cache in raster order, with border flags and SOF/EOF.
// Latency: first cell valid MEM_LAT+1 cycles after start is accepted; 1 cell/cycle sustained.
// Backpressure: reads issue only against free FIFO credits, so fwd_cell_ready_i low stalls issue.
// Ports: start_i/cfg_* frame request; busy_o/done_o status; bwd_* cache read
// (fixed MEM_LAT response); fwd_* cell stream with valid/ready handshake.
module cell_stream_fetch
  import cell_fetch_pkg::*;
#(
  parameter  int CELL_WIDTH   = 768,
  parameter  int CACHE_DEPTH  = 2048,
  parameter  int MAX_ROW_CNUM = 64,
  parameter  int MAX_COL_CNUM = 64,
  parameter  int MEM_LAT      = 2,
  parameter  int FIFO_DEPTH   = MEM_LAT + 1,   // must be >= MEM_LAT+1
  localparam int ADDR_W       = $clog2(CACHE_DEPTH),
  localparam int ROW_W        = $clog2(MAX_ROW_CNUM + 1),
  localparam int COL_W        = $clog2(MAX_COL_CNUM + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     cfg_base_addr_i,
  input  logic [ROW_W-1:0]      cfg_row_cnum_i,
  input  logic [COL_W-1:0]      cfg_col_cnum_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_W-1:0]     bwd_cell_addr_o,
  output logic                  bwd_cell_rd_vld,
  input  logic [CELL_WIDTH-1:0] bwd_cell_data_i,
  input  logic                  bwd_cell_rd_rdy,
  output logic [CELL_WIDTH-1:0] fwd_cell_data_o,
  output logic [3:0]            fwd_cell_flag_o,
  output logic                  fwd_cell_sof_o,
  output logic                  fwd_cell_eof_o,
  output logic                  fwd_cell_valid_o,
  input  logic                  fwd_cell_ready_i
);

  localparam int FW    = CELL_WIDTH + TAG_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W  = $clog2(MEM_LAT + 1);

  fetch_state_t     state;
  logic [ROW_W-1:0] cfg_rows;
  logic [COL_W-1:0] cfg_cols;
  logic [ADDR_W-1:0] addr;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  // Delay line mirroring reads in flight; stage k holds the read issued k+1 cycles ago
  logic [MEM_LAT-1:0] pipe_vld;
  logic [TAG_W-1:0]   pipe_tag [MEM_LAT];
  logic [IF_W-1:0]    inflight;

  logic [FW-1:0]    fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             issue;
  logic             credit_ok;
  logic             at_top, at_bottom, at_left, at_right, at_last;
  logic [TAG_W-1:0] issue_tag;

  // Sticky: response with no matching read, or a push into a full FIFO.
  // Not a port; observed hierarchically during debug.
  logic             dbg_rdy_err;

  assign at_top    = (row == '0);
  assign at_bottom = (row == cfg_rows - ROW_W'(1));
  assign at_left   = (col == '0);
  assign at_right  = (col == cfg_cols - COL_W'(1));
  assign at_last   = at_bottom && at_right;
  assign issue_tag = pack_tag(at_top, at_bottom, at_left, at_right, at_top && at_left, at_last);

  always_comb begin
    inflight = '0;
    for (int k = 0; k < MEM_LAT; k++) inflight = inflight + IF_W'(pipe_vld[k]);
  end

  // A pop this cycle frees its slot immediately, keeping 1 cell/cycle with ready high
  assign credit_ok = (32'(fifo_count) + 32'(inflight)) < (32'(FIFO_DEPTH) + 32'(pop));
  assign issue     = (state == ST_FETCH) && credit_ok;

  assign bwd_cell_rd_vld = issue;
  assign bwd_cell_addr_o = addr;

  assign push = bwd_cell_rd_rdy && pipe_vld[MEM_LAT-1];
  assign pop  = fwd_cell_valid_o && fwd_cell_ready_i;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({bwd_cell_data_i, pipe_tag[MEM_LAT-1]}),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign fwd_cell_valid_o = !fifo_empty;
  assign fwd_cell_data_o  = fifo_head[TAG_W +: CELL_WIDTH];
  assign fwd_cell_flag_o  = fifo_head[TAG_W-1 -: 4];
  assign fwd_cell_sof_o   = fifo_head[TAG_SOF];
  assign fwd_cell_eof_o   = fifo_head[TAG_EOF];

  always_ff @(posedge clk) begin
    for (int k = 0; k < MEM_LAT; k++) begin
      if (k == 0) pipe_tag[k] <= issue_tag;
      else        pipe_tag[k] <= pipe_tag[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cfg_rows    <= '0;
      cfg_cols    <= '0;
      addr        <= '0;
      row         <= '0;
      col         <= '0;
      pipe_vld    <= '0;
      dbg_rdy_err <= 1'b0;
    end else begin
      done_o <= 1'b0;

      for (int k = 0; k < MEM_LAT; k++) begin
        if (k == 0) pipe_vld[k] <= issue;
        else        pipe_vld[k] <= pipe_vld[k-1];
      end

      if ((bwd_cell_rd_rdy && !pipe_vld[MEM_LAT-1]) || (push && fifo_full && !pop))
        dbg_rdy_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (cfg_row_cnum_i != '0 && cfg_col_cnum_i != '0) begin
              cfg_rows <= cfg_row_cnum_i;
              cfg_cols <= cfg_col_cnum_i;
              addr     <= cfg_base_addr_i;
              row      <= '0;
              col      <= '0;
              busy_o   <= 1'b1;
              state    <= ST_FETCH;
            end else begin
              // Empty frame completes immediately
              done_o <= 1'b1;
            end
          end
        end

        ST_FETCH: begin
          if (issue) begin
            addr <= (addr == ADDR_W'(CACHE_DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
            if (at_right) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
            if (at_last) state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          // Finish on the handshake that empties the FIFO with nothing left in flight,
          // so done_o lands exactly one cycle after the final cell is taken
          if (pipe_vld == '0 && pop && fifo_count == CNT_W'(1)) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_stream_fetch.sv
module tb_cell_stream_fetch;

  localparam int CW  = 768;
  localparam int AW  = 11;
  localparam int RW  = 7;
  localparam int CLW = 7;
  localparam int LAT = 2;
  localparam int FD  = 3;

  typedef struct packed {
    logic [CW-1:0] data;
    logic [3:0]    flag;
    logic          sof;
    logic          eof;
  } cell_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [AW-1:0]  cfg_base;
  logic [RW-1:0]  cfg_rows;
  logic [CLW-1:0] cfg_cols;
  logic           busy, done;
  logic [AW-1:0]  bwd_addr;
  logic           bwd_rd_vld;
  logic [CW-1:0]  mem_data = '0;
  logic           mem_rdy = 1'b0;
  logic           inj_rdy;
  logic           bwd_rdy;
  logic [CW-1:0]  fwd_data;
  logic [3:0]     fwd_flag;
  logic           fwd_sof, fwd_eof, fwd_valid;
  logic           fwd_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bwd_rdy = mem_rdy | inj_rdy;

  cell_stream_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .cfg_base_addr_i  (cfg_base),
    .cfg_row_cnum_i   (cfg_rows),
    .cfg_col_cnum_i   (cfg_cols),
    .busy_o           (busy),
    .done_o           (done),
    .bwd_cell_addr_o  (bwd_addr),
    .bwd_cell_rd_vld  (bwd_rd_vld),
    .bwd_cell_data_i  (mem_data),
    .bwd_cell_rd_rdy  (bwd_rdy),
    .fwd_cell_data_o  (fwd_data),
    .fwd_cell_flag_o  (fwd_flag),
    .fwd_cell_sof_o   (fwd_sof),
    .fwd_cell_eof_o   (fwd_eof),
    .fwd_cell_valid_o (fwd_valid),
    .fwd_cell_ready_i (fwd_ready)
  );

  // Cache content is a pure function of address
  function automatic logic [CW-1:0] make_data(input int addr);
    logic [CW-1:0] d;
    for (int k = 0; k < CW/32; k++)
      d[k*32 +: 32] = (32'(addr) * 32'h9E3779B1) ^ (32'(k) * 32'h01010101) ^ 32'h5A5A0000;
    return d;
  endfunction

  // Cache model: answers each read exactly LAT cycles after it was issued
  logic [LAT-1:0] hist = '0;
  int             hist_addr [LAT];
  always @(negedge clk) begin
    mem_rdy  = hist[LAT-1];
    mem_data = make_data(hist_addr[LAT-1]);
    for (int k = LAT-1; k > 0; k--) begin
      hist[k]      = hist[k-1];
      hist_addr[k] = hist_addr[k-1];
    end
    hist[0]      = bwd_rd_vld;
    hist_addr[0] = int'(bwd_addr);
  end

  // Reference model: cell i of a rows x cols frame starting at base
  function automatic cell_t exp_cell(input int base, input int rows, input int cols, input int i);
    cell_t e;
    int r, c;
    r = i / cols;
    c = i % cols;
    e.data = make_data((base + i) % 2048);
    e.flag = {r == 0, r == rows - 1, c == 0, c == cols - 1};
    e.sof  = (i == 0);
    e.eof  = (i == rows * cols - 1);
    return e;
  endfunction

  cell_t rx [$];
  int    iss_cyc [$];
  int    iss_addr [$];
  int    first_vld, done_cyc, last_hs, hold_viol, busy_bad;

  function automatic int first_bad(input int base, input int rows, input int cols);
    foreach (rx[i]) if (rx[i] !== exp_cell(base, rows, cols, i)) return i;
    return -1;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Starts a frame and records everything until done_o or the cycle budget.
  // Cycle 0 is the cycle after the edge that samples start_i.
  task automatic run_frame(input int base, input int rows, input int cols, input int hold_low,
                           input int pct, input int extra_start, input int budget);
    cell_t cur, prev;
    bit    prev_stall;
    rx.delete(); iss_cyc.delete(); iss_addr.delete();
    first_vld = -1; done_cyc = -1; last_hs = -1; hold_viol = 0; busy_bad = 0;
    prev_stall = 1'b0; prev = '0;
    cfg_base = AW'(base); cfg_rows = RW'(rows); cfg_cols = CLW'(cols); start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
      if (cyc == extra_start) begin
        start = 1'b1; cfg_base = '0; cfg_rows = RW'(1); cfg_cols = CLW'(1);
      end else begin
        start = 1'b0;
      end
      fwd_ready = (cyc >= hold_low) && ($urandom_range(99) < pct);
      @(negedge clk);
      cur = {fwd_data, fwd_flag, fwd_sof, fwd_eof};
      if (prev_stall && (!fwd_valid || cur !== prev)) hold_viol++;
      prev_stall = fwd_valid && !fwd_ready;
      prev = cur;
      if (fwd_valid && first_vld < 0) first_vld = cyc;
      if (bwd_rd_vld) begin iss_cyc.push_back(cyc); iss_addr.push_back(int'(bwd_addr)); end
      if (fwd_valid && fwd_ready) begin rx.push_back(cur); last_hs = cyc; end
      if (done) done_cyc = cyc;
      else if (!busy) busy_bad++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    fwd_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bwd_rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld got %b want 0", bwd_rd_vld); end
    checks++; if (fwd_valid !== 1'b0)  begin errors++; $display("FAIL reset_fwd_valid got %b want 0", fwd_valid); end
  endtask

  task automatic test_basic();
    int bad_iss, bad;
    run_frame(16, 3, 4, 0, 100, -1, 200);
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL basic_done timeout got %0d want >=0", done_cyc); end
    bad_iss = (iss_addr.size() == 12) ? 0 : 1;
    foreach (iss_addr[i]) if (iss_addr[i] != 16 + i || iss_cyc[i] != i) bad_iss++;
    checks++; if (bad_iss !== 0) begin errors++; $display("FAIL basic_issue count %0d bad %0d want 12 bad 0", iss_addr.size(), bad_iss); end
    checks++; if (first_vld !== LAT + 1) begin errors++; $display("FAIL basic_first_valid got %0d want %0d", first_vld, LAT + 1); end
    checks++; if (rx.size() !== 12) begin errors++; $display("FAIL basic_count got %0d want 12", rx.size()); end
    bad = first_bad(16, 3, 4);
    checks++; if (bad !== -1) begin errors++; $display("FAIL basic_cells first bad index %0d want -1", bad); end
    if (rx.size() == 12) begin
      checks++; if (rx[0].flag !== 4'b1010)  begin errors++; $display("FAIL basic_flag00 got %b want 1010", rx[0].flag); end
      checks++; if (rx[11].flag !== 4'b0101) begin errors++; $display("FAIL basic_flag23 got %b want 0101", rx[11].flag); end
    end
    checks++; if (done_cyc !== last_hs + 1) begin errors++; $display("FAIL basic_done_timing got %0d want %0d", done_cyc, last_hs + 1); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL basic_busy low cycles %0d want 0", busy_bad); end
  endtask

  task automatic test_backpressure();
    int early, bad;
    run_frame(16, 3, 4, 20, 100, -1, 300);
    early = 0;
    foreach (iss_cyc[i]) if (iss_cyc[i] < 20) early++;
    checks++; if (early !== FD) begin errors++; $display("FAIL bp_stalled_issues got %0d want %0d", early, FD); end
    checks++; if (rx.size() !== 12) begin errors++; $display("FAIL bp_count got %0d want 12", rx.size()); end
    bad = first_bad(16, 3, 4);
    checks++; if (bad !== -1) begin errors++; $display("FAIL bp_cells first bad index %0d want -1", bad); end
    checks++; if (last_hs !== 31) begin errors++; $display("FAIL bp_resume_rate last handshake %0d want 31", last_hs); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold_stable violations %0d want 0", hold_viol); end
  endtask

  task automatic test_random();
    int base, bad, nsof, neof;
    base = int'($urandom_range(2047));
    run_frame(base, 30, 40, 0, 50, -1, 20000);
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL rand_done timeout got %0d want >=0", done_cyc); end
    checks++; if (rx.size() !== 1200) begin errors++; $display("FAIL rand_count got %0d want 1200", rx.size()); end
    bad = first_bad(base, 30, 40);
    checks++; if (bad !== -1) begin errors++; $display("FAIL rand_cells first bad index %0d want -1", bad); end
    nsof = 0; neof = 0;
    foreach (rx[i]) begin nsof += int'(rx[i].sof); neof += int'(rx[i].eof); end
    checks++; if (nsof !== 1 || neof !== 1) begin errors++; $display("FAIL rand_sof_eof got %0d/%0d want 1/1", nsof, neof); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL rand_hold_stable violations %0d want 0", hold_viol); end
    checks++; if (done_cyc !== last_hs + 1) begin errors++; $display("FAIL rand_done_timing got %0d want %0d", done_cyc, last_hs + 1); end
  endtask

  task automatic test_wrap();
    int want [4] = '{'h7FE, 'h7FF, 'h000, 'h001};
    int bad;
    run_frame('h7FE, 1, 4, 0, 100, -1, 100);
    checks++; if (iss_addr.size() !== 4) begin errors++; $display("FAIL wrap_issue_count got %0d want 4", iss_addr.size()); end
    for (int i = 0; i < 4 && i < iss_addr.size(); i++) begin
      checks++; if (iss_addr[i] !== want[i]) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", i, iss_addr[i], want[i]); end
    end
    bad = first_bad('h7FE, 1, 4);
    checks++; if (bad !== -1 || rx.size() !== 4) begin errors++; $display("FAIL wrap_cells first bad %0d count %0d want -1/4", bad, rx.size()); end
  endtask

  task automatic test_zero_dim();
    int rdv;
    run_frame(0, 0, 5, 0, 100, -1, 10);
    checks++; if (done_cyc !== 0) begin errors++; $display("FAIL zero_rows_done got %0d want 0", done_cyc); end
    run_frame(0, 4, 0, 0, 100, -1, 10);
    checks++; if (done_cyc !== 0) begin errors++; $display("FAIL zero_cols_done got %0d want 0", done_cyc); end
    rdv = iss_addr.size();
    repeat (5) begin
      @(negedge clk);
      if (bwd_rd_vld || busy) rdv++;
      @(posedge clk); #1;
    end
    checks++; if (rdv !== 0) begin errors++; $display("FAIL zero_no_reads got %0d want 0", rdv); end
  endtask

  task automatic test_start_ignored();
    int bad;
    run_frame('h100, 3, 4, 0, 100, 2, 200);
    checks++; if (rx.size() !== 12) begin errors++; $display("FAIL ign_count got %0d want 12", rx.size()); end
    bad = first_bad('h100, 3, 4);
    checks++; if (bad !== -1) begin errors++; $display("FAIL ign_cells first bad index %0d want -1", bad); end
  endtask

  task automatic test_single();
    run_frame(5, 1, 1, 0, 100, -1, 50);
    checks++; if (rx.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", rx.size()); end
    if (rx.size() == 1) begin
      checks++;
      if (rx[0] !== exp_cell(5, 1, 1, 0) || rx[0].flag !== 4'b1111 || !rx[0].sof || !rx[0].eof) begin
        errors++; $display("FAIL single_cell got flag %b sof %b eof %b want 1111 1 1", rx[0].flag, rx[0].sof, rx[0].eof);
      end
    end
  endtask

  task automatic test_reset_mid();
    int leaked, bad;
    cfg_base = AW'(0); cfg_rows = RW'(3); cfg_cols = CLW'(4); fwd_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;       // cycle 0
    @(posedge clk); #1;                    // cycle 1
    @(posedge clk); #1;                    // cycle 2: two reads in flight
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || bwd_rd_vld !== 1'b0 || fwd_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got busy %b rd %b vld %b done %b want 0000", busy, bwd_rd_vld, fwd_valid, done);
    end
    leaked = 0;
    repeat (6) begin
      @(negedge clk);
      if (fwd_valid || bwd_rd_vld) leaked++;
      @(posedge clk); #1;
    end
    checks++; if (leaked !== 0) begin errors++; $display("FAIL rstmid_dropped got %0d want 0", leaked); end
    run_frame('h40, 2, 2, 0, 100, -1, 100);
    bad = first_bad('h40, 2, 2);
    checks++; if (bad !== -1 || rx.size() !== 4) begin errors++; $display("FAIL rstmid_next_frame first bad %0d count %0d want -1/4", bad, rx.size()); end
  endtask

  task automatic test_orphan_rdy();
    do_reset(2);
    run_frame('h20, 2, 3, 0, 100, -1, 100);
    checks++; if (dut.dbg_rdy_err !== 1'b0) begin errors++; $display("FAIL orphan_clean got %b want 0", dut.dbg_rdy_err); end
    inj_rdy = 1'b1;
    @(posedge clk); #1 inj_rdy = 1'b0;
    @(posedge clk); #1;
    checks++; if (dut.dbg_rdy_err !== 1'b1 || fwd_valid !== 1'b0) begin
      errors++; $display("FAIL orphan_flag got err %b vld %b want 1 0", dut.dbg_rdy_err, fwd_valid);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_rows = '0; cfg_cols = '0;
    fwd_ready = 1'b0; inj_rdy = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_wrap();
    test_zero_dim();
    test_start_ignored();
    test_single();
    test_reset_mid();
    test_orphan_rdy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
